// File: rtl/seg_msg_pkg.sv
// seg_msg_pkg: shared FSM state type and default message length for seg_msg_sequencer
package seg_msg_pkg;
  localparam int MSG_LEN_DEF = 14;
  typedef enum logic [1:0] {MANUAL, AUTO, PAUSED} state_t;
endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: 2-flop synchronizer, stable-level debouncer and rising-edge press pulse
module btn_debounce #(
  parameter int DB_CYCLES = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_i,
  output logic press_o
);
  localparam int W = $clog2(DB_CYCLES + 1);
  localparam logic [W-1:0] LAST = W'(DB_CYCLES - 1);
  logic s1, s2, lvl, done;
  logic [W-1:0] cnt;
  assign done = (s2 != lvl) && (cnt == LAST);
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      lvl <= 1'b0;
      cnt <= '0;
      press_o <= 1'b0;
    end else begin
      s1 <= btn_i;
      s2 <= s1;
      cnt <= (s2 == lvl || done) ? '0 : cnt + 1'b1;
      lvl <= done ? s2 : lvl;
      press_o <= done & s2;
    end
  end
endmodule

// File: rtl/seg_msg_sequencer.sv
// seg_msg_sequencer: message index stepper with manual presses and optional auto scroll.
// Auto scroll (AUTO/PAUSED states and timer) is built only when AUTO_SCROLL_EN is defined.
module seg_msg_sequencer
  import seg_msg_pkg::*;
#(
  parameter int MSG_LEN = MSG_LEN_DEF,
  parameter int DB_CYCLES = 50000,
  parameter int SCROLL_DIV = 12000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_i,
  input  logic       mode_i,
  input  logic       pause_i,
  output logic [3:0] index_o,
  output logic       step_o,
  output logic       busy_o
);
  localparam logic [3:0] LAST_IDX = 4'(MSG_LEN - 1);
  logic press, adv;
  logic [3:0] idx_next;
  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db (
    .clk(clk),
    .rst(rst),
    .btn_i(btn_i),
    .press_o(press)
  );
  assign idx_next = (index_o == LAST_IDX) ? 4'd0 : index_o + 4'd1;
  always_ff @(posedge clk) begin
    if (rst) begin
      index_o <= 4'd0;
      step_o <= 1'b0;
    end else begin
      index_o <= adv ? idx_next : index_o;
      step_o <= adv;
    end
  end
`ifdef AUTO_SCROLL_EN
  localparam int TW = $clog2(SCROLL_DIV);
  localparam logic [TW-1:0] TC = TW'(SCROLL_DIV - 1);
  state_t state, nxt;
  logic [TW-1:0] timer;
  logic tick, tc;
  always_comb begin
    nxt = !mode_i ? MANUAL : (state == MANUAL || !pause_i) ? AUTO : PAUSED;
  end
  // the timer only runs on cycles that stay in AUTO, so a pause freezes it exactly
  assign tick = (state == AUTO) && (nxt == AUTO);
  assign tc = timer == TC;
  assign adv = press | (tick & tc);
  assign busy_o = state == AUTO;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= MANUAL;
      timer <= '0;
    end else begin
      state <= nxt;
      timer <= (nxt == MANUAL || (state == AUTO && press) || (tick && tc)) ? '0
             : tick ? timer + 1'b1 : timer;
    end
  end
`else
  logic unused_cfg;
  assign unused_cfg = mode_i ^ pause_i;
  assign adv = press;
  assign busy_o = 1'b0;
`endif
endmodule

// File: tb/tb_seg_msg_sequencer.sv
// tb_seg_msg_sequencer: directed self-checking bench (MSG_LEN=14, DB_CYCLES=4, SCROLL_DIV=10)
module tb_seg_msg_sequencer;
  logic clk = 1'b0, rst = 1'b1, btn = 1'b0, mode = 1'b0, pause = 1'b0;
  logic [3:0] index;
  logic step, busy;
  int n_checks = 0, n_fail = 0, steps = 0, first = 0, max_idx = 0;

  seg_msg_sequencer #(.MSG_LEN(14), .DB_CYCLES(4), .SCROLL_DIV(10)) dut (
    .clk(clk),
    .rst(rst),
    .btn_i(btn),
    .mode_i(mode),
    .pause_i(pause),
    .index_o(index),
    .step_o(step),
    .busy_o(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // advance n clock edges, sampling 1 time unit after each; first = edge number of first step_o
  task automatic run(input int n);
    steps = 0;
    first = 0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (int'(index) > max_idx) max_idx = int'(index);
      if (step) begin
        steps++;
        if (first == 0) first = i + 1;
      end
    end
  endtask

  initial begin
    int tot;
    run(2);
    check("rst_index", int'(index), 0);
    check("rst_step", int'(step), 0);
    check("rst_busy", int'(busy), 0);
    rst = 1'b0;
    tot = 0;
    for (int p = 1; p <= 14; p++) begin
      btn = 1'b1;
      run(10);
      tot += steps;
      btn = 1'b0;
      run(10);
      tot += steps;
      check($sformatf("wrap_idx%0d", p), int'(index), p % 14);
    end
    check("wrap_steps", tot, 14);
    btn = 1'b1;
    run(3);
    btn = 1'b0;
    run(10);
    check("glitch_steps", steps, 0);
    check("glitch_idx", int'(index), 0);
    btn = 1'b1;
    run(20);
    check("db_steps", steps, 1);
    check("db_latency", first, 7);
    check("db_idx", int'(index), 1);
    btn = 1'b0;
    run(10);
    check("release_steps", steps, 0);
    btn = 1'b1;
    run(4);
    rst = 1'b1;
    run(1);
    check("midrst_idx", int'(index), 0);
    check("midrst_step", int'(step), 0);
    rst = 1'b0;
    run(10);
    check("held_steps", steps, 1);
    check("held_latency", first, 7);
    check("held_idx", int'(index), 1);
    btn = 1'b0;
    run(10);
    rst = 1'b1;
    run(1);
    rst = 1'b0;
`ifdef AUTO_SCROLL_EN
    mode = 1'b1;
    run(35);
    check("auto_steps", steps, 3);
    check("auto_first", first, 11);
    check("auto_idx", int'(index), 3);
    check("auto_busy", int'(busy), 1);
    run(2);
    pause = 1'b1;
    btn = 1'b1;
    run(10);
    check("pause_press_steps", steps, 1);
    check("pause_press_idx", int'(index), 4);
    btn = 1'b0;
    run(10);
    check("pause_steps", steps, 0);
    check("pause_busy", int'(busy), 0);
    pause = 1'b0;
    run(5);
    check("resume_steps", steps, 1);
    check("resume_first", first, 5);
    check("resume_idx", int'(index), 5);
    run(3);
    btn = 1'b1;
    run(7);
    check("coll_steps", steps, 1);
    check("coll_first", first, 7);
    check("coll_idx", int'(index), 6);
    btn = 1'b0;
    run(10);
    check("post_coll_steps", steps, 1);
    check("post_coll_first", first, 10);
    check("post_coll_idx", int'(index), 7);
    run(8);
    rst = 1'b1;
    run(1);
    check("arst_idx", int'(index), 0);
    check("arst_busy", int'(busy), 0);
    check("arst_step", int'(step), 0);
    rst = 1'b0;
    run(1);
    check("reenter_busy", int'(busy), 1);
    mode = 1'b0;
    pause = 1'b1;
    run(1);
    check("mode_prio_busy", int'(busy), 0);
    pause = 1'b0;
    run(12);
    check("manual_nostep", steps, 0);
`else
    mode = 1'b1;
    pause = 1'b0;
    run(50);
    check("off_steps", steps, 0);
    check("off_busy", int'(busy), 0);
    check("off_idx", int'(index), 0);
    btn = 1'b1;
    run(10);
    check("off_press_steps", steps, 1);
    check("off_press_first", first, 7);
    check("off_press_idx", int'(index), 1);
    btn = 1'b0;
    run(10);
`endif
    check("max_index", max_idx, 13);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/seg_msg_sequencer.md
SEG_MSG_SEQUENCER -- requirements
Module: seg_msg_sequencer

Interface
REQ-001 SHALL have parameter MSG_LEN, default 14, number of message characters; index wraps at MSG_LEN-1; legal range 2..16.
REQ-002 SHALL have parameter DB_CYCLES, default 50000, number of cycles a synchronized button level must be stable before it is accepted.
REQ-003 SHALL have parameter SCROLL_DIV, default 12000000, clock cycles per automatic advance.
REQ-004 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have port btn_i  input  1  raw asynchronous step button, active high.
REQ-007 SHALL have port mode_i  input  1  0 = manual step, 1 = auto scroll; level, synchronous to clk.
REQ-008 SHALL have port pause_i  input  1  freezes auto scroll while high; level, synchronous.
REQ-009 SHALL have port index_o  output  4  current character index, registered.
REQ-010 SHALL have port step_o  output  1  one-cycle pulse, coincident with the cycle in which index_o first shows a new value.
REQ-011 SHALL have port busy_o  output  1  high while in AUTO state.

Function
REQ-012 SHALL pass btn_i through a 2-flop synchronizer, then a debouncer that updates its accepted level only after DB_CYCLES consecutive equal synchronized samples.
REQ-013 SHALL generate one press pulse on each 0->1 transition of the accepted level; holding the button yields exactly one press.
REQ-014 SHALL produce the press pulse 2+DB_CYCLES+1 cycles after btn_i rises and stays high; glitches shorter than DB_CYCLES SHALL produce no press.
REQ-015 SHALL implement FSM states MANUAL, AUTO, PAUSED.
REQ-016 Transitions SHALL be: MANUAL->AUTO when mode_i=1; AUTO->PAUSED when pause_i=1; PAUSED->AUTO when pause_i=0; AUTO or PAUSED->MANUAL when mode_i=0 (mode_i has priority over pause_i).
REQ-017 In MANUAL, each press SHALL advance index_o by 1 on the next cycle.
REQ-018 In AUTO, a timer counting 0..SCROLL_DIV-1 SHALL advance index_o on the cycle after terminal count and restart at 0.
REQ-019 In AUTO, a press SHALL advance index_o immediately and clear the timer; a press coincident with terminal count SHALL produce a single advance.
REQ-020 In PAUSED, the timer SHALL hold its value and presses SHALL still advance index_o.
REQ-021 Entering AUTO from MANUAL SHALL clear the timer; entering from PAUSED SHALL resume the held value.
REQ-022 Advance SHALL be index_o = (index_o == MSG_LEN-1) ? 0 : index_o + 1; index_o SHALL never exceed MSG_LEN-1.
REQ-023 Timer width SHALL be $clog2(SCROLL_DIV); debounce counter width SHALL be $clog2(DB_CYCLES+1).

Reset
REQ-024 On rst=1 at a clock edge: index_o=0, step_o=0, busy_o=0, state=MANUAL, timer=0, synchronizer flops=0, accepted level=0, debounce counter=0.
REQ-025 Reset asserted mid-debounce or mid-scroll SHALL discard the pending press or advance; a button still held after reset SHALL register as a new press once debounced.

Configuration
REQ-026 With AUTO_SCROLL_EN defined, states AUTO and PAUSED, the timer, and SCROLL_DIV behaviour SHALL be present as specified.
REQ-027 Without AUTO_SCROLL_EN, the FSM SHALL be fixed at MANUAL, no timer SHALL be synthesized, mode_i and pause_i SHALL be ignored, and busy_o SHALL be tied to 0.

Structure
REQ-028 Package seg_msg_pkg SHALL hold the FSM state typedef (MANUAL, AUTO, PAUSED) and the default MSG_LEN constant.
REQ-029 Synchronizer, debouncer and edge detector SHALL be sub-module btn_debounce (ports clk, rst, btn_i, press_o); the FSM, timer and index SHALL be in the top module.

Verification (MSG_LEN=14, DB_CYCLES=4, SCROLL_DIV=10, AUTO_SCROLL_EN defined unless stated)
REQ-030 Manual wrap: mode_i=0, 14 clean presses -> index_o steps 1..13 then 0, 14 step_o pulses.
REQ-031 Debounce: btn_i high 3 cycles then low -> no step_o; btn_i high 20 cycles -> exactly one step_o, 7 cycles after the rise.
REQ-032 Auto scroll: mode_i=1 for 35 cycles -> step_o every 10 cycles; index_o reaches 3; busy_o=1.
REQ-033 Pause/press: in AUTO with timer at 6, pause_i=1 for 20 cycles -> no auto step; a press during the pause advances index_o by 1; after pause_i=0, the next auto step occurs 4 cycles later.
REQ-034 Collision and reset: a press coincident with timer terminal count -> index_o +1 only; rst asserted with timer at 8 -> index_o=0, state=MANUAL next cycle.
REQ-035 Config off: AUTO_SCROLL_EN undefined, mode_i=1 for 50 cycles -> no step_o, busy_o=0; presses still advance index_o.
